// File: rtl/tl_ul_arbiter_2to1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tl_ul_arbiter_2to1: two TL-UL hosts sharing one TL-UL device, with       |
// | in-order response routing. Optional: TL_ARB_FIXED_PRIORITY_EN (host 0    |
// | always wins contention). Revision: 1.0                                   |
// +--------------------------------------------------------------------------+

package tl_ul_arbiter_2to1_pkg;

  localparam logic [2:0] c_OP_PUT_FULL = 3'd0;
  localparam logic [2:0] c_OP_GET      = 3'd4;
  localparam logic [2:0] c_OP_ACK      = 3'd0;
  localparam logic [2:0] c_OP_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_m2s_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_s2m_t;

endpackage

module tl_ul_arbiter_2to1
  import tl_ul_arbiter_2to1_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tl_m2s_t                tl_h0_i,
  output tl_s2m_t                tl_h0_o,
  input  tl_m2s_t                tl_h1_i,
  output tl_s2m_t                tl_h1_o,
  output tl_m2s_t                tl_d_o,
  input  tl_s2m_t                tl_d_i,
  output logic [$clog2(Depth):0] outstanding_o,
  output logic                   route_err_o
);

  localparam int unsigned       c_PTR_W = $clog2(Depth);
  localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(Depth);

  generate
    if ((Depth < 2) || (Depth > 16) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
      $error("tl_ul_arbiter_2to1: Depth must be a power of two in 2..16");
    end
  endgenerate

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W:0]   count_q, count_d;
  logic [Depth-1:0]   id_mem_q, id_mem_d;
  logic               lock_q, lock_d;
  logic               lock_id_q, lock_id_d;

  logic w_full, w_empty, w_gnt, w_win_valid, w_head_id;
  logic w_a_fire, w_d_fire;

  assign w_full    = (count_q == c_DEPTH);
  assign w_empty   = (count_q == '0);
  assign w_head_id = id_mem_q[rd_ptr_q];

`ifdef TL_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_gnt = 1'b0;
    if (lock_q) begin
      w_gnt = lock_id_q;
    end else if (!tl_h0_i.a_valid) begin
      w_gnt = tl_h1_i.a_valid;
    end
  end
`else
  logic rr_q, rr_d;

  // rr_q names the host that wins when both request.
  always_comb begin
    w_gnt = 1'b0;
    if (lock_q) begin
      w_gnt = lock_id_q;
    end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
      w_gnt = rr_q;
    end else begin
      w_gnt = tl_h1_i.a_valid;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (w_a_fire) begin
      rr_d = ~w_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign w_win_valid = w_gnt ? tl_h1_i.a_valid : tl_h0_i.a_valid;

  // Outputs are gated by rst_ni so nothing handshakes while reset is held.
  always_comb begin
    tl_d_o         = w_gnt ? tl_h1_i : tl_h0_i;
    tl_d_o.a_valid = rst_ni & w_win_valid & ~w_full;
    tl_d_o.d_ready = rst_ni & ~w_empty & (w_head_id ? tl_h1_i.d_ready : tl_h0_i.d_ready);
  end

  always_comb begin
    tl_h0_o         = tl_d_i;
    tl_h0_o.a_ready = rst_ni & ~w_full & tl_d_i.a_ready & ~w_gnt;
    tl_h0_o.d_valid = rst_ni & ~w_empty & tl_d_i.d_valid & ~w_head_id;
    tl_h1_o         = tl_d_i;
    tl_h1_o.a_ready = rst_ni & ~w_full & tl_d_i.a_ready & w_gnt;
    tl_h1_o.d_valid = rst_ni & ~w_empty & tl_d_i.d_valid & w_head_id;
  end

  assign route_err_o   = rst_ni & tl_d_i.d_valid & w_empty;
  assign outstanding_o = count_q;

  assign w_a_fire = tl_d_o.a_valid & tl_d_i.a_ready;
  assign w_d_fire = tl_d_i.d_valid & tl_d_o.d_ready;

  always_comb begin
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_a_fire) begin
      id_mem_d[wr_ptr_q] = w_gnt;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (w_d_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_a_fire, w_d_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The grant stays with a host from the first unaccepted presentation until
  // its handshake, including cycles where a full FIFO masks a_valid.
  always_comb begin
    lock_id_d = w_gnt;
    lock_d    = w_win_valid & ~w_a_fire & (lock_q | tl_d_o.a_valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_mem_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      id_mem_q  <= id_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tl_ul_arbiter_2to1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tl_ul_arbiter_2to1: directed self-checking bench for the arbiter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_tl_ul_arbiter_2to1;
  import tl_ul_arbiter_2to1_pkg::*;

  localparam int unsigned c_DEPTH = 4;
  localparam logic [31:0] c_ADDR0 = 32'h0000_1000;
  localparam logic [31:0] c_ADDR1 = 32'h0000_2000;

  logic       clk;
  logic       rst_ni;
  tl_m2s_t    h0_i, h1_i, d_o;
  tl_s2m_t    h0_o, h1_o, d_i;
  logic [2:0] outstanding;
  logic       route_err;

  int n_vec;
  int n_err;

  tl_ul_arbiter_2to1 #(.Depth(c_DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tl_h0_i      (h0_i),
    .tl_h0_o      (h0_o),
    .tl_h1_i      (h1_i),
    .tl_h1_o      (h1_o),
    .tl_d_o       (d_o),
    .tl_d_i       (d_i),
    .outstanding_o(outstanding),
    .route_err_o  (route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    h0_i = '0;
    h1_i = '0;
    d_i  = '0;
    h0_i.a_opcode  = c_OP_GET;
    h0_i.a_address = c_ADDR0;
    h0_i.a_source  = 8'h10;
    h0_i.a_mask    = 4'hF;
    h0_i.a_size    = 2'd2;
    h1_i.a_opcode  = c_OP_GET;
    h1_i.a_address = c_ADDR1;
    h1_i.a_source  = 8'h21;
    h1_i.a_mask    = 4'hF;
    h1_i.a_size    = 2'd2;
    d_i.d_opcode   = c_OP_ACK_DATA;
    d_i.d_size     = 2'd2;
  endtask

  task automatic reset_dut();
    idle_all();
    @(posedge clk);
    #1 rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    idle_all();
    #2 rst_ni = 1'b0;
    h0_i.a_valid = 1'b1;
    h1_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    d_i.d_valid  = 1'b1;
    h0_i.d_ready = 1'b1;
    #1;
    n_vec++; if (d_o.a_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid: got %0b expected 0", d_o.a_valid); end
    n_vec++; if (h0_o.a_ready !== 1'b0 || h1_o.a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %0b%0b expected 00", h0_o.a_ready, h1_o.a_ready); end
    n_vec++; if (h0_o.d_valid !== 1'b0 || h1_o.d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid: got %0b%0b expected 00", h0_o.d_valid, h1_o.d_valid); end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    n_vec++; if (route_err !== 1'b0) begin n_err++; $display("FAIL rst_route_err: got %0b expected 0", route_err); end
    idle_all();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  // Both hosts hold a Get; grants and responses follow issue order.
  task automatic test_round_robin();
    logic [3:0] exp_h;
`ifdef TL_ARB_FIXED_PRIORITY_EN
    exp_h = 4'b0000;
`else
    exp_h = 4'b1010;
`endif
    reset_dut();
    h0_i.a_valid = 1'b1;
    h1_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (d_o.a_address !== (exp_h[i] ? c_ADDR1 : c_ADDR0)) begin n_err++; $display("FAIL rr_grant[%0d]: got %0h expected %0h", i, d_o.a_address, exp_h[i] ? c_ADDR1 : c_ADDR0); end
      n_vec++; if ({h1_o.a_ready, h0_o.a_ready} !== (exp_h[i] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_a_ready[%0d]: got %b expected %b", i, {h1_o.a_ready, h0_o.a_ready}, exp_h[i] ? 2'b10 : 2'b01); end
      tick();
    end
    h0_i.a_valid = 1'b0;
    h1_i.a_valid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL rr_outstanding: got %0d expected 4", outstanding); end
    h0_i.d_ready = 1'b1;
    h1_i.d_ready = 1'b1;
    d_i.d_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_i.d_data = 32'hD000_0000 + i;
      #1;
      n_vec++; if ({h1_o.d_valid, h0_o.d_valid} !== (exp_h[i] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_resp_route[%0d]: got %b expected %b", i, {h1_o.d_valid, h0_o.d_valid}, exp_h[i] ? 2'b10 : 2'b01); end
      n_vec++; if ((exp_h[i] ? h1_o.d_data : h0_o.d_data) !== 32'hD000_0000 + i) begin n_err++; $display("FAIL rr_resp_data[%0d]: got %0h expected %0h", i, exp_h[i] ? h1_o.d_data : h0_o.d_data, 32'hD000_0000 + i); end
      tick();
    end
    d_i.d_valid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rr_drain: got %0d expected 0", outstanding); end
  endtask

  // Host 0 is stalled by the device; host 1 must not steal the grant.
  task automatic test_lock();
    reset_dut();
    h0_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    tick();
    d_i.a_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) h1_i.a_valid = 1'b1;
      #1;
      n_vec++; if (d_o.a_address !== c_ADDR0 || d_o.a_valid !== 1'b1) begin n_err++; $display("FAIL lock_hold[%0d]: got %0h/%0b expected %0h/1", i, d_o.a_address, d_o.a_valid, c_ADDR0); end
      n_vec++; if (h1_o.a_ready !== 1'b0) begin n_err++; $display("FAIL lock_h1_ready[%0d]: got %0b expected 0", i, h1_o.a_ready); end
      tick();
    end
    d_i.a_ready = 1'b1;
    #1;
    n_vec++; if (d_o.a_address !== c_ADDR0 || h0_o.a_ready !== 1'b1) begin n_err++; $display("FAIL lock_release: got %0h/%0b expected %0h/1", d_o.a_address, h0_o.a_ready, c_ADDR0); end
    tick();
`ifdef TL_ARB_FIXED_PRIORITY_EN
    n_vec++; if (d_o.a_address !== c_ADDR0) begin n_err++; $display("FAIL lock_next: got %0h expected %0h", d_o.a_address, c_ADDR0); end
`else
    n_vec++; if (d_o.a_address !== c_ADDR1 || h1_o.a_ready !== 1'b1) begin n_err++; $display("FAIL lock_next: got %0h/%0b expected %0h/1", d_o.a_address, h1_o.a_ready, c_ADDR1); end
`endif
    idle_all();
  endtask

  // Six attempts against a 4-deep id FIFO with no responses.
  task automatic test_full();
    int n_acc;
    n_acc = 0;
    reset_dut();
    h0_i.a_valid = 1'b1;
    h1_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    h0_i.d_ready = 1'b1;
    h1_i.d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (d_o.a_valid && d_i.a_ready) n_acc++;
      tick();
    end
    n_vec++; if (n_acc !== 4) begin n_err++; $display("FAIL full_accepts: got %0d expected 4", n_acc); end
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    n_vec++; if ({h1_o.a_ready, h0_o.a_ready, d_o.a_valid} !== 3'b000) begin n_err++; $display("FAIL full_stall: got %b expected 000", {h1_o.a_ready, h0_o.a_ready, d_o.a_valid}); end
    d_i.d_valid = 1'b1;
    #1;
    n_vec++; if (d_o.d_ready !== 1'b1 || d_o.a_valid !== 1'b0) begin n_err++; $display("FAIL full_no_bypass: got d_ready %0b a_valid %0b expected 1 0", d_o.d_ready, d_o.a_valid); end
    tick();
    d_i.d_valid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd3 || d_o.a_valid !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got %0d/%0b expected 3/1", outstanding, d_o.a_valid); end
    tick();
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    idle_all();
  endtask

  // Head belongs to host 1, which back-pressures the D channel.
  task automatic test_d_backpressure();
    reset_dut();
    h1_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    tick();
    h1_i.a_valid = 1'b0;
    h0_i.d_ready = 1'b1;
    h1_i.d_ready = 1'b0;
    d_i.d_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if ({d_o.d_ready, h0_o.d_valid, h1_o.d_valid} !== 3'b001) begin n_err++; $display("FAIL bp_hold[%0d]: got %b expected 001", i, {d_o.d_ready, h0_o.d_valid, h1_o.d_valid}); end
      tick();
      n_vec++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL bp_no_pop[%0d]: got %0d expected 1", i, outstanding); end
    end
    h1_i.d_ready = 1'b1;
    #1;
    n_vec++; if (d_o.d_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %0b expected 1", d_o.d_ready); end
    tick();
    d_i.d_valid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL bp_pop: got %0d expected 0", outstanding); end
    idle_all();
  endtask

  // Stray response with nothing outstanding, then an asynchronous reset.
  task automatic test_route_err();
    reset_dut();
    h0_i.d_ready = 1'b1;
    h1_i.d_ready = 1'b1;
    d_i.d_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if ({route_err, h0_o.d_valid, h1_o.d_valid, d_o.d_ready} !== 4'b1000) begin n_err++; $display("FAIL rerr_pulse[%0d]: got %b expected 1000", i, {route_err, h0_o.d_valid, h1_o.d_valid, d_o.d_ready}); end
      tick();
    end
    d_i.d_valid = 1'b0;
    #1;
    n_vec++; if (route_err !== 1'b0) begin n_err++; $display("FAIL rerr_clear: got %0b expected 0", route_err); end
    h0_i.a_valid = 1'b1;
    d_i.a_ready  = 1'b1;
    tick();
    tick();
    n_vec++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL rerr_preload: got %0d expected 2", outstanding); end
    rst_ni = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0 || d_o.a_valid !== 1'b0) begin n_err++; $display("FAIL rerr_async_rst: got %0d/%0b expected 0/0", outstanding, d_o.a_valid); end
    tick();
    rst_ni = 1'b1;
    idle_all();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_d_backpressure();
    test_route_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
